// File: rtl/scu_pkg.sv
// Shared definitions for the SCU datapath: opcode map and
// the fetch-stage state encoding.
package scu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SVPC = 4'b1111;
    localparam logic [OPC_W-1:0] OP_LD   = 4'b1110;
    localparam logic [OPC_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_INC  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_NEG  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_J    = 4'b1000;
    localparam logic [OPC_W-1:0] OP_BRZ  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_JM   = 4'b1010;
    localparam logic [OPC_W-1:0] OP_BRN  = 4'b1011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: resolved redirect from execute wins,
// otherwise sequential +1 (wrapping) when fetch advances.
module pc_next #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              advance,
    input  logic              Jump,
    input  logic              JumpMem,
    input  logic              Branch_Zero,
    input  logic              Branch_Neg,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [ADDR_W-1:0] mem_target,
    output logic              take,
    output logic [ADDR_W-1:0] npc
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] seq_pc;

    assign take = Jump | JumpMem
                | (Branch_Zero & flag_z)
                | (Branch_Neg & flag_n);

    assign target = JumpMem ? mem_target : reg_target;

    assign seq_pc = advance ? (pc + ONE) : pc;

    // Redirect has priority over sequential advance
    always_comb begin
        npc = seq_pc;
        if (take) begin
            npc = target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/valid handshake, one-entry
// skid for stalled responses, and the IF/ID register.
module fetch_stage
    import scu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,

    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,

    input  logic               stall,

    input  logic               Jump,
    input  logic               JumpMem,
    input  logic               Branch_Zero,
    input  logic               Branch_Neg,
    input  logic               flag_z,
    input  logic               flag_n,
    input  logic [ADDR_W-1:0]  reg_target,
    input  logic [ADDR_W-1:0]  mem_target,

    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [OPC_W-1:0]   ifid_opcode,
    output logic [ADDR_W-1:0]  ifid_pc
);

    localparam logic [INSTR_W-1:0] NOP_WORD =
        {OP_NOP, {(INSTR_W-OPC_W){1'b0}}};

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic               kill;
    logic [INSTR_W-1:0] skid_instr;

    logic               req_on;
    logic               hold;
    logic               accept;
    logic               advance;
    logic               take;
    logic [ADDR_W-1:0]  npc;

    assign req_on = (state == S_REQ) || (state == S_WAIT);
    assign hold   = (state == S_HOLD);

    // A response belongs to us only if it was not orphaned
    // by an earlier redirect.
    assign accept  = req_on & imem_valid & ~kill;
    assign advance = ~stall & (accept | hold);

    // Request drops the moment reset asserts, not a cycle later.
    assign imem_req  = req_on & ~reset;
    assign imem_addr = pc;

    assign ifid_opcode = ifid_instr[INSTR_W-1 -: OPC_W];

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc          (pc),
        .advance     (advance),
        .Jump        (Jump),
        .JumpMem     (JumpMem),
        .Branch_Zero (Branch_Zero),
        .Branch_Neg  (Branch_Neg),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .reg_target  (reg_target),
        .mem_target  (mem_target),
        .take        (take),
        .npc         (npc)
    );

    // Fetch FSM, PC, kill flag, skid and IF/ID register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            skid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
            ifid_pc    <= '0;
        end else if (take) begin
            // Flush; a request still in flight must be dropped
            // when its response eventually arrives.
            pc         <= npc;
            state      <= S_REQ;
            kill       <= req_on & ~imem_valid;
            skid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_WORD;
        end else begin
            unique case (state)
                S_REQ, S_WAIT: begin
                    if (imem_valid && kill) begin
                        kill  <= 1'b0;
                        state <= S_WAIT;
                        if (!stall) begin
                            ifid_valid <= 1'b0;
                            ifid_instr <= NOP_WORD;
                        end
                    end else if (imem_valid && !stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= imem_rdata;
                        ifid_pc    <= pc;
                        pc         <= npc;
                        state      <= S_REQ;
                    end else if (imem_valid) begin
                        skid_instr <= imem_rdata;
                        state      <= S_HOLD;
                    end else begin
                        state <= S_WAIT;
                        if (!stall) begin
                            ifid_valid <= 1'b0;
                            ifid_instr <= NOP_WORD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= skid_instr;
                        ifid_pc    <= pc;
                        skid_instr <= NOP_WORD;
                        pc         <= npc;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table
// plus an asynchronous reset sequence.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Jump;
    logic        JumpMem;
    logic        Branch_Zero;
    logic        Branch_Neg;
    logic        flag_z;
    logic        flag_n;
    logic [31:0] reg_target;
    logic [31:0] mem_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [3:0]  ifid_opcode;
    logic [31:0] ifid_pc;

    int n_run  = 0;
    int n_fail = 0;

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .Jump        (Jump),
        .JumpMem     (JumpMem),
        .Branch_Zero (Branch_Zero),
        .Branch_Neg  (Branch_Neg),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .reg_target  (reg_target),
        .mem_target  (mem_target),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_opcode (ifid_opcode),
        .ifid_pc     (ifid_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ctl = {stall, Jump, JumpMem, Branch_Zero, Branch_Neg, flag_z, flag_n}
    localparam logic [6:0] C0 = 7'b0000000;
    localparam logic [6:0] ST = 7'b1000000;
    localparam logic [6:0] CJ = 7'b0100000;
    localparam logic [6:0] JM = 7'b0010000;
    localparam logic [6:0] BZ = 7'b0001000;
    localparam logic [6:0] BN = 7'b0000100;
    localparam logic [6:0] FZ = 7'b0000010;
    localparam logic [6:0] FN = 7'b0000001;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [6:0]  ctl;
        logic [31:0] rt;
        logic [31:0] mt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] d,
                       input logic [6:0] ctl, input logic [31:0] rt,
                       input logic [31:0] mt, input logic e_req,
                       input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t t;
        t.v = v; t.d = d; t.ctl = ctl; t.rt = rt; t.mt = mt;
        t.e_req = e_req; t.e_addr = e_addr; t.e_iv = e_iv;
        t.e_instr = e_instr; t.e_pc = e_pc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req,
                           input logic [31:0] e_addr, input logic e_iv,
                           input logic [31:0] e_instr, input logic [31:0] e_pc);
        logic [31:0] ei;
        ei = e_instr;
        chk({tag, ".req"},   32'(imem_req),    32'(e_req));
        chk({tag, ".addr"},  imem_addr,        e_addr);
        chk({tag, ".iv"},    32'(ifid_valid),  32'(e_iv));
        chk({tag, ".instr"}, ifid_instr,       ei);
        chk({tag, ".opc"},   32'(ifid_opcode), 32'(ei[31:28]));
        chk({tag, ".pc"},    ifid_pc,          e_pc);
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [6:0] ctl, input logic [31:0] rt,
                         input logic [31:0] mt);
        imem_valid  = v;
        imem_rdata  = d;
        stall       = ctl[6];
        Jump        = ctl[5];
        JumpMem     = ctl[4];
        Branch_Zero = ctl[3];
        Branch_Neg  = ctl[2];
        flag_z      = ctl[1];
        flag_n      = ctl[0];
        reg_target  = rt;
        mem_target  = mt;
    endtask

    initial begin
        // sequential fetch, 1-cycle memory
        add(0, 0,            C0, 0, 0, 1, 32'h10, 0, 0,            0);
        add(1, 32'h40000010, C0, 0, 0, 1, 32'h11, 1, 32'h40000010, 32'h10);
        add(0, 0,            C0, 0, 0, 1, 32'h11, 0, 0,            32'h10);
        add(1, 32'h50000011, C0, 0, 0, 1, 32'h12, 1, 32'h50000011, 32'h11);
        add(0, 0,            C0, 0, 0, 1, 32'h12, 0, 0,            32'h11);
        add(1, 32'h60000012, C0, 0, 0, 1, 32'h13, 1, 32'h60000012, 32'h12);
        // same-cycle valid: one per cycle
        add(1, 32'h70000013, C0, 0, 0, 1, 32'h14, 1, 32'h70000013, 32'h13);
        add(1, 32'h40000014, C0, 0, 0, 1, 32'h15, 1, 32'h40000014, 32'h14);
        // branches not taken
        add(1, 32'h40000015, BZ, 32'h40, 0, 1, 32'h16, 1, 32'h40000015, 32'h15);
        add(0, 0, BZ | BN, 32'h40, 0, 1, 32'h16, 0, 0, 32'h15);
        // BRZ taken with simultaneous valid: no kill
        add(1, 32'h90000016, BZ | FZ, 32'h05, 0, 1, 32'h05, 0, 0, 32'h15);
        add(0, 0,            C0, 0, 0, 1, 32'h05, 0, 0, 32'h15);
        // Jump while 0x05 outstanding: kill old word
        add(0, 0,            CJ, 32'h40, 0, 1, 32'h40, 0, 0, 32'h15);
        add(1, 32'hA0000005, C0, 0, 0, 1, 32'h40, 0, 0, 32'h15);
        add(0, 0,            C0, 0, 0, 1, 32'h40, 0, 0, 32'h15);
        add(1, 32'h40000040, C0, 0, 0, 1, 32'h41, 1, 32'h40000040, 32'h40);
        // JumpMem selects mem_target
        add(0, 0, JM, 32'h33, 32'h80, 1, 32'h80, 0, 0, 32'h40);
        add(1, 32'h12345678, C0, 0, 0, 1, 32'h80, 0, 0, 32'h40);
        add(1, 32'h50000080, C0, 0, 0, 1, 32'h81, 1, 32'h50000080, 32'h80);
        // stall over a response: skid then release
        add(0, 0,            ST, 0, 0, 1, 32'h81, 1, 32'h50000080, 32'h80);
        add(1, 32'h60000081, ST, 0, 0, 0, 32'h81, 1, 32'h50000080, 32'h80);
        add(0, 0,            ST, 0, 0, 0, 32'h81, 1, 32'h50000080, 32'h80);
        add(1, 32'hDEADBEEF, ST, 0, 0, 0, 32'h81, 1, 32'h50000080, 32'h80);
        add(0, 0,            C0, 0, 0, 1, 32'h82, 1, 32'h60000081, 32'h81);
        add(0, 0,            C0, 0, 0, 1, 32'h82, 0, 0,            32'h81);
        // taken BRN overrides stall, target all-ones
        add(0, 0, ST | BN | FN, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h81);
        add(1, 32'h11111111, C0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h81);
        // PC wraps to zero
        add(1, 32'hB0000000, C0, 0, 0, 1, 32'h0, 1, 32'hB0000000, 32'hFFFFFFFF);
        // take from HOLD: no kill, skid dropped
        add(1, 32'hF0000000, ST, 0, 0, 0, 32'h0, 1, 32'hB0000000, 32'hFFFFFFFF);
        add(0, 0, ST | CJ, 32'h20, 0, 1, 32'h20, 0, 0, 32'hFFFFFFFF);
        add(1, 32'h40000020, C0, 0, 0, 1, 32'h21, 1, 32'h40000020, 32'h20);

        drive(0, 0, C0, 0, 0);
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all("rst", 0, 32'h10, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_all("rst_rel", 1, 32'h10, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].ctl,
                  vecs[i].rt, vecs[i].mt);
            @(posedge clock);
            #1;
            chk_all($sformatf("v%0d", i + 1), vecs[i].e_req,
                    vecs[i].e_addr, vecs[i].e_iv,
                    vecs[i].e_instr, vecs[i].e_pc);
            @(negedge clock);
        end

        // reset while a request to 0x21 is outstanding
        drive(0, 0, C0, 0, 0);
        @(posedge clock);
        #1;
        chk_all("pre_rst", 1, 32'h21, 0, 0, 32'h20);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 32'h10, 0, 0, 0);
        @(negedge clock);
        drive(1, 32'hDEADBEEF, C0, 0, 0);
        @(posedge clock);
        #1;
        chk_all("late_valid", 0, 32'h10, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, C0, 0, 0);
        reset = 1'b0;
        #1;
        chk_all("rst2_rel", 1, 32'h10, 0, 0, 0);
        @(posedge clock);
        #1;
        chk_all("rst2_wait", 1, 32'h10, 0, 0, 0);
        @(negedge clock);
        drive(1, 32'h70000010, C0, 0, 0);
        @(posedge clock);
        #1;
        chk_all("rst2_load", 1, 32'h11, 1, 32'h70000010, 32'h10);
        @(negedge clock);
        drive(0, 0, C0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
